mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_ctrl_pkg.sv | 16 +
 rtl/mips_cycle_ctr.sv | 22 ++
 rtl/mips_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_run_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller.
// Holds the state encoding and the cycle-counter saturation value.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CRST   = 3'd2,
      S_HALTED = 3'd3,
      S_RUN    = 3'd4,
      S_STEP   = 3'd5
   } state_t;

   localparam logic [31:0] CYC_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cycle_ctr.sv
// Saturating executed-cycle counter.
// Ports: clk, rst_n (async low), clear, enable -> count[31:0].
module mips_cycle_ctr
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != CYC_SAT)
         count <= count + 32'd1;
   end

endmodule

// File: rtl/mips_run_ctrl.sv
// Program-load and run/step/halt controller for a MIPS core.
// Ports: CLK, RST (async low); LOAD_REQ/VALID/DATA/LAST -> LOAD_READY,
// WE, W_Ins; RUN, STEP, HALT_REQ, PC, BP_ADDR -> CORE_RST_N, CORE_CE,
// STATE, CYCLES, BP_HIT. Macro MIPS_RUN_CTRL_BP_EN enables the breakpoint.
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int RSTHOLD   = 2,
   parameter int MAX_WORDS = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD_REQ,
   input  logic        LOAD_VALID,
   input  logic [31:0] LOAD_DATA,
   input  logic        LOAD_LAST,
   output logic        LOAD_READY,
   input  logic        RUN,
   input  logic        STEP,
   input  logic        HALT_REQ,
   input  logic [31:0] PC,
   input  logic [31:0] BP_ADDR,
   output logic        WE,
   output logic [31:0] W_Ins,
   output logic        CORE_RST_N,
   output logic        CORE_CE,
   output logic [2:0]  STATE,
   output logic [31:0] CYCLES,
   output logic        BP_HIT
);

   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam logic [WCW-1:0] WLAST = WCW'(MAX_WORDS - 1);
   localparam logic [3:0] HLAST = 4'(RSTHOLD - 1);

   state_t         state;
   state_t         state_nx;
   logic [WCW-1:0] wcnt;
   logic [3:0]     hcnt;
   logic           xfer;
   logic           last_word;
   logic           bp_match;
   logic           crst_entry;
   logic           load_entry;
   logic           ce;

   assign xfer       = LOAD_VALID && LOAD_READY;
   assign last_word  = LOAD_LAST || (wcnt == WLAST);
   assign crst_entry = (state_nx == S_CRST) && (state != S_CRST);
   assign load_entry = (state_nx == S_LOAD) && (state != S_LOAD);
   assign STATE      = state;
   assign CORE_CE    = ce;

`ifdef MIPS_RUN_CTRL_BP_EN
   assign bp_match = (PC == BP_ADDR);
`else
   logic unused_bp;
   assign unused_bp = ^{PC, BP_ADDR};
   assign bp_match  = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (LOAD_REQ) state_nx = S_LOAD;
         S_LOAD:
            if (xfer && last_word) state_nx = S_CRST;
         S_CRST:
            if (hcnt == HLAST) state_nx = S_HALTED;
         S_HALTED:
            if (LOAD_REQ)      state_nx = S_LOAD;
            else if (HALT_REQ) state_nx = S_HALTED;
            else if (STEP)     state_nx = S_STEP;
            else if (RUN)      state_nx = S_RUN;
         S_RUN:
            if (HALT_REQ || bp_match) state_nx = S_HALTED;
         S_STEP:
            state_nx = S_HALTED;
         default:
            state_nx = S_IDLE;
      endcase
   end

   // The breakpoint gates the enable in the same cycle; STEP ignores it
   // so the core can be stepped off a breakpoint address.
   always_comb begin
      ce = 1'b0;
      unique case (state)
         S_RUN:   ce = !bp_match;
         S_STEP:  ce = 1'b1;
         default: ce = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wcnt       <= '0;
         hcnt       <= '0;
         LOAD_READY <= 1'b0;
         WE         <= 1'b0;
         W_Ins      <= '0;
         CORE_RST_N <= 1'b0;
      end else begin
         if (load_entry)
            wcnt <= '0;
         else if (xfer)
            wcnt <= wcnt + WCW'(1);
         if (crst_entry)
            hcnt <= '0;
         else if (state == S_CRST)
            hcnt <= hcnt + 4'd1;
         LOAD_READY <= (state_nx == S_LOAD);
         WE         <= xfer;
         if (xfer)
            W_Ins <= LOAD_DATA;
         // Low from reset until the first CRST finishes, then only in CRST.
         if (state_nx == S_CRST)
            CORE_RST_N <= 1'b0;
         else if (state == S_CRST)
            CORE_RST_N <= 1'b1;
      end
   end

`ifdef MIPS_RUN_CTRL_BP_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         BP_HIT <= 1'b0;
      else if (crst_entry)
         BP_HIT <= 1'b0;
      else if (state == S_RUN && bp_match)
         BP_HIT <= 1'b1;
   end
`else
   assign BP_HIT = 1'b0;
`endif

   mips_cycle_ctr u_ctr (
      .clk    (CLK),
      .rst_n  (RST),
      .clear  (crst_entry),
      .enable (ce),
      .count  (CYCLES)
   );

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl (MAX_WORDS=4, RSTHOLD=2).
// Covers reset, load, overflow, step, breakpoint/priority, reset mid-load.
module tb_mips_run_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        LOAD_REQ = 1'b0;
   logic        LOAD_VALID = 1'b0;
   logic [31:0] LOAD_DATA = '0;
   logic        LOAD_LAST = 1'b0;
   logic        LOAD_READY;
   logic        RUN = 1'b0;
   logic        STEP = 1'b0;
   logic        HALT_REQ = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] BP_ADDR = '0;
   logic        WE;
   logic [31:0] W_Ins;
   logic        CORE_RST_N;
   logic        CORE_CE;
   logic [2:0]  STATE;
   logic [31:0] CYCLES;
   logic        BP_HIT;

   int vecs = 0;
   int errs = 0;
   int we_cnt = 0;
   int ce_cnt = 0;
   int w0;
   int c0;

   logic [31:0] prog [3] = '{32'h20080005, 32'h20090003, 32'h01095020};

   always #5 CLK = ~CLK;

   mips_run_ctrl #(.RSTHOLD(2), .MAX_WORDS(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .LOAD_REQ   (LOAD_REQ),
      .LOAD_VALID (LOAD_VALID),
      .LOAD_DATA  (LOAD_DATA),
      .LOAD_LAST  (LOAD_LAST),
      .LOAD_READY (LOAD_READY),
      .RUN        (RUN),
      .STEP       (STEP),
      .HALT_REQ   (HALT_REQ),
      .PC         (pc),
      .BP_ADDR    (BP_ADDR),
      .WE         (WE),
      .W_Ins      (W_Ins),
      .CORE_RST_N (CORE_RST_N),
      .CORE_CE    (CORE_CE),
      .STATE      (STATE),
      .CYCLES     (CYCLES),
      .BP_HIT     (BP_HIT)
   );

   // Core PC model: restarts at 0 under core reset, advances on enable.
   always @(posedge CLK) begin
      if (!CORE_RST_N)
         pc <= '0;
      else if (CORE_CE)
         pc <= pc + 32'd4;
   end

   always @(negedge CLK) begin
      if (WE) we_cnt++;
      if (CORE_CE) ce_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #3;
      check("rst_state", 32'(STATE), 32'd0);
      check("rst_we", 32'(WE), 32'd0);
      check("rst_wins", W_Ins, 32'd0);
      check("rst_rdy", 32'(LOAD_READY), 32'd0);
      check("rst_crstn", 32'(CORE_RST_N), 32'd0);
      check("rst_ce", 32'(CORE_CE), 32'd0);
      check("rst_cyc", CYCLES, 32'd0);
      check("rst_bp", 32'(BP_HIT), 32'd0);
      tick();
      tick();
      RST = 1'b1;
      tick();
      check("idle_state", 32'(STATE), 32'd0);
      check("idle_crstn", 32'(CORE_RST_N), 32'd0);

      // Three-word program with LAST on the third
      LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      check("ld_state", 32'(STATE), 32'd1);
      check("ld_rdy", 32'(LOAD_READY), 32'd1);
      check("ld_crstn", 32'(CORE_RST_N), 32'd0);
      w0 = we_cnt;
      for (int i = 0; i < 3; i++) begin
         LOAD_VALID = 1'b1;
         LOAD_DATA  = prog[i];
         LOAD_LAST  = (i == 2);
         tick();
         check("ld_we", 32'(WE), 32'd1);
         check("ld_wins", W_Ins, prog[i]);
      end
      LOAD_VALID = 1'b0;
      LOAD_LAST  = 1'b0;
      check("crst1_state", 32'(STATE), 32'd2);
      check("crst1_crstn", 32'(CORE_RST_N), 32'd0);
      check("crst1_rdy", 32'(LOAD_READY), 32'd0);
      tick();
      check("crst2_state", 32'(STATE), 32'd2);
      check("crst2_crstn", 32'(CORE_RST_N), 32'd0);
      check("crst2_we", 32'(WE), 32'd0);
      tick();
      check("hlt_state", 32'(STATE), 32'd3);
      check("hlt_crstn", 32'(CORE_RST_N), 32'd1);
      check("hlt_ce", 32'(CORE_CE), 32'd0);
      check("ld_wecnt", 32'(we_cnt - w0), 32'd3);

      // Three single steps
      check("st_cyc0", CYCLES, 32'd0);
      c0 = ce_cnt;
      for (int i = 0; i < 3; i++) begin
         STEP = 1'b1;
         tick();
         STEP = 1'b0;
         check("st_state", 32'(STATE), 32'd5);
         check("st_ce", 32'(CORE_CE), 32'd1);
         tick();
         check("st_back", 32'(STATE), 32'd3);
         check("st_ce_off", 32'(CORE_CE), 32'd0);
      end
      check("st_cyc", CYCLES, 32'd3);
      check("st_cecnt", 32'(ce_cnt - c0), 32'd3);

      // Overflow: six words offered, no LAST, MAX_WORDS=4
      LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      w0 = we_cnt;
      LOAD_VALID = 1'b1;
      for (int i = 0; i < 6; i++) begin
         LOAD_DATA = 32'hA000_0000 + 32'(i);
         tick();
         if (i == 3) begin
            check("ovf_rdy", 32'(LOAD_READY), 32'd0);
            check("ovf_crst", 32'(STATE), 32'd2);
         end
      end
      LOAD_VALID = 1'b0;
      check("ovf_state", 32'(STATE), 32'd3);
      check("ovf_wecnt", 32'(we_cnt - w0), 32'd4);
      check("ovf_wins", W_Ins, 32'hA000_0003);
      check("ovf_cyc", CYCLES, 32'd0);

      // Run from PC 0 with breakpoint at 0x8
      BP_ADDR = 32'h8;
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      check("run_state", 32'(STATE), 32'd4);
      check("run_ce0", 32'(CORE_CE), 32'd1);
      tick();
      check("run_ce4", 32'(CORE_CE), 32'd1);
      tick();
`ifdef MIPS_RUN_CTRL_BP_EN
      check("bp_ce", 32'(CORE_CE), 32'd0);
      tick();
      check("bp_state", 32'(STATE), 32'd3);
      check("bp_hit", 32'(BP_HIT), 32'd1);
      check("bp_cyc", CYCLES, 32'd2);
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      check("bp_step_ce", 32'(CORE_CE), 32'd1);
      tick();
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      check("pr_run", 32'(STATE), 32'd4);
      HALT_REQ = 1'b1;
      STEP     = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      STEP     = 1'b0;
      check("pr_state", 32'(STATE), 32'd3);
      check("pr_ce", 32'(CORE_CE), 32'd0);
      check("pr_cyc", CYCLES, 32'd4);
      tick();
      check("pr_cyc2", CYCLES, 32'd4);
`else
      check("nobp_ce", 32'(CORE_CE), 32'd1);
      HALT_REQ = 1'b1;
      STEP     = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      STEP     = 1'b0;
      check("pr_state", 32'(STATE), 32'd3);
      check("pr_ce", 32'(CORE_CE), 32'd0);
      check("pr_cyc", CYCLES, 32'd3);
      check("nobp_hit", 32'(BP_HIT), 32'd0);
      tick();
      check("pr_cyc2", CYCLES, 32'd3);
`endif

      // Reset in the middle of a load, then reload from word 1
      LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      LOAD_VALID = 1'b1;
      for (int i = 0; i < 2; i++) begin
         LOAD_DATA = 32'hB000_0000 + 32'(i);
         tick();
      end
      LOAD_VALID = 1'b0;
      #2 RST = 1'b0;
      #1;
      check("mr_state", 32'(STATE), 32'd0);
      check("mr_we", 32'(WE), 32'd0);
      check("mr_rdy", 32'(LOAD_READY), 32'd0);
      check("mr_crstn", 32'(CORE_RST_N), 32'd0);
      check("mr_cyc", CYCLES, 32'd0);
      #2 RST = 1'b1;
      tick();
      LOAD_REQ = 1'b1;
      tick();
      LOAD_REQ = 1'b0;
      LOAD_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         LOAD_DATA = 32'hC000_0000 + 32'(i);
         tick();
         if (i == 2) check("rl_w3", 32'(STATE), 32'd1);
      end
      LOAD_VALID = 1'b0;
      check("rl_w4", 32'(STATE), 32'd2);
      tick();
      tick();
      check("rl_hlt", 32'(STATE), 32'd3);
      check("rl_crstn", 32'(CORE_RST_N), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
